// File: rtl/spi_pkg.sv
// Shared SPI master types and decode helpers.
// Ports: none; FSM state enum, word length and SCK half-period tables.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_XFER,
    S_TRAIL,
    S_GAP
  } state_t;

  localparam int HALF_W = 5;
  localparam int BITS_W = 6;

  // word_len 0..3 -> 8/16/24/32 bits
  function automatic logic [BITS_W-1:0] word_bits(
    input logic [1:0] len
  );
    return {({1'b0, len} + 3'd1), 3'b000};
  endfunction

  // sck_speed 0..3 -> 2/4/8/16 GCLK cycles per SCK half period
  function automatic logic [HALF_W-1:0] half_period(
    input logic [1:0] sp
  );
    return 5'd2 << sp;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK generator: half-period and edge counters, edge strobes, SCK register.
// Ports: clk/rst, run (XFER), idle/idle_pol/cpol, half, nedge -> sck, lead/trail/first/last strobes.
module spi_clk_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       idle,
  input  logic       idle_pol,
  input  logic       cpol,
  input  logic [4:0] half,
  input  logic [6:0] nedge,
  output logic       sck,
  output logic       lead,
  output logic       trail,
  output logic       first,
  output logic       last
);

  logic [4:0] hcnt;
  logic [6:0] ecnt;
  logic       tick;

  // Strobes fire in the cycle whose closing clock edge toggles SCK
  assign tick  = run && (hcnt == half - 5'd1);
  assign lead  = tick && !ecnt[0];
  assign trail = tick && ecnt[0];
  assign first = tick && (ecnt == 7'd0);
  assign last  = tick && (ecnt == nedge - 7'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      ecnt <= '0;
      sck  <= 1'b0;
    end else if (!run) begin
      hcnt <= '0;
      ecnt <= '0;
      sck  <= idle ? idle_pol : cpol;
    end else if (tick) begin
      hcnt <= '0;
      ecnt <= ecnt + 7'd1;
      sck  <= ~sck;
    end else begin
      hcnt <= hcnt + 5'd1;
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// SPI master shift engine: single full-duplex MSB-first transfer per start.
// Ports: GCLK/RST, start + config + mosi_data in, busy/done/miso_data out, SCK/CS_N/MOSI/MISO pins.
module spi_master_core
  import spi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DLY_W  = 8
) (
  input  logic              GCLK,
  input  logic              RST,
  input  logic              start,
  input  logic [1:0]        spi_mode,
  input  logic [1:0]        sck_speed,
  input  logic [1:0]        word_len,
  input  logic [DLY_W-1:0]  ifg,
  input  logic [DLY_W-1:0]  cs_sck,
  input  logic [DLY_W-1:0]  sck_cs,
  input  logic [DATA_W-1:0] mosi_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] miso_data,
  output logic              SCK,
  output logic              CS_N,
  output logic              MOSI,
  input  logic              MISO
);

  state_t state, nstate;

  logic [DLY_W-1:0]  dcnt;
  logic [DLY_W-1:0]  lead_lim;
  logic [DLY_W-1:0]  trail_lim;
  logic [1:0]        c_mode;
  logic [HALF_W-1:0] c_half;
  logic [BITS_W-1:0] c_bits;
  logic [DLY_W-1:0]  c_ifg;
  logic [DLY_W-1:0]  c_cs_sck;
  logic [DLY_W-1:0]  c_sck_cs;
  logic [DATA_W-1:0] tx;
  logic [DATA_W-1:0] rx;
  logic [DATA_W-1:0] tx_load;
  logic              accept;
  logic              trail_end;
  logic              lead_stb;
  logic              trail_stb;
  logic              first_stb;
  logic              last_stb;

  assign accept    = (state == S_IDLE) && start;
  assign lead_lim  = (c_cs_sck == '0) ? DLY_W'(1) : c_cs_sck;
  assign trail_lim = (c_sck_cs == '0) ? DLY_W'(1) : c_sck_cs;
  assign trail_end = (state == S_TRAIL) &&
                     (dcnt == trail_lim - DLY_W'(1));

  // TX word is left-justified so MOSI is always the top bit
  assign tx_load = mosi_data << (DATA_W - int'(word_bits(word_len)));
  assign MOSI    = tx[DATA_W-1];

  spi_clk_gen u_clk (
    .clk      (GCLK),
    .rst      (RST),
    .run      (state == S_XFER),
    .idle     (state == S_IDLE),
    .idle_pol (spi_mode[1]),
    .cpol     (c_mode[1]),
    .half     (c_half),
    .nedge    ({c_bits, 1'b0}),
    .sck      (SCK),
    .lead     (lead_stb),
    .trail    (trail_stb),
    .first    (first_stb),
    .last     (last_stb)
  );

  always_ff @(posedge GCLK) begin
    if (RST) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:  if (start) nstate = S_LEAD;
      S_LEAD:  if (dcnt == lead_lim - DLY_W'(1)) nstate = S_XFER;
      S_XFER:  if (last_stb) nstate = S_TRAIL;
      S_TRAIL: if (trail_end) nstate = (c_ifg == '0) ? S_IDLE : S_GAP;
      S_GAP:   if (dcnt == c_ifg - DLY_W'(1)) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b1;
    CS_N = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        CS_N = 1'b1;
      end
      S_GAP:   CS_N = 1'b1;
      default: ;
    endcase
  end

  // Delay counter restarts on every state change
  always_ff @(posedge GCLK) begin
    if (RST)                  dcnt <= '0;
    else if (nstate != state) dcnt <= '0;
    else                      dcnt <= dcnt + DLY_W'(1);
  end

  always_ff @(posedge GCLK) begin
    if (RST) begin
      c_mode    <= '0;
      c_half    <= '0;
      c_bits    <= '0;
      c_ifg     <= '0;
      c_cs_sck  <= '0;
      c_sck_cs  <= '0;
      tx        <= '0;
      rx        <= '0;
      done      <= 1'b0;
      miso_data <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        c_mode   <= spi_mode;
        c_half   <= half_period(sck_speed);
        c_bits   <= word_bits(word_len);
        c_ifg    <= ifg;
        c_cs_sck <= cs_sck;
        c_sck_cs <= sck_cs;
        tx       <= tx_load;
        rx       <= '0;
      end
      if (lead_stb) begin
        if (!c_mode[0])      rx <= {rx[DATA_W-2:0], MISO};
        else if (!first_stb) tx <= tx << 1;
      end
      if (trail_stb) begin
        if (c_mode[0])      rx <= {rx[DATA_W-2:0], MISO};
        else if (!last_stb) tx <= tx << 1;
      end
      if (trail_end) begin
        done      <= 1'b1;
        miso_data <= rx;
      end
    end
  end

endmodule
